// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared channel state encoding and divider limits
package clk_div_pkg;
  typedef enum logic {ST_BYPASS = 1'b0, ST_RUN = 1'b1} state_e;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: per-channel enables/ratios in, divided clocks/ticks/lock out
interface clk_div_multi_if #(parameter int NUM_CH = 4, parameter int RATIO_W = 8);
  logic [NUM_CH-1:0]         i_clk_en;
  logic [NUM_CH*RATIO_W-1:0] i_div_ratio;
  logic [NUM_CH-1:0]         o_div_clk;
  logic [NUM_CH-1:0]         o_tick;
  logic [NUM_CH-1:0]         o_locked;
  modport master (output i_clk_en, i_div_ratio, input o_div_clk, o_tick, o_locked);
  modport slave (input i_clk_en, i_div_ratio, output o_div_clk, o_tick, o_locked);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (i_ref_clk, i_rst, i_clk_en, i_div_ratio -> o_div_clk, o_tick, o_locked)
module clk_div_chan import clk_div_pkg::*; #(
  parameter int RATIO_W = 8
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  output logic               o_div_clk,
  output logic               o_tick,
  output logic               o_locked
);
  state_e             state_q, state_d;
  logic [RATIO_W-1:0] act_ratio_q, act_ratio_d, cnt_q, cnt_d, half;
  logic               act_en_q, act_en_d, div_q, div_d, tick_q, tick_d, bnd, go_run;
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q     <= ST_BYPASS;
      act_ratio_q <= '0;
      act_en_q    <= 1'b0;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_ratio_q <= act_ratio_d;
      act_en_q    <= act_en_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
    end
  end
  // Inputs are only sampled at a boundary, so a new mode/ratio always starts a fresh period
  always_comb begin
    bnd         = (state_q == ST_RUN) ? (cnt_q == act_ratio_q - RATIO_W'(1)) : 1'b1;
    go_run      = i_clk_en && (i_div_ratio >= RATIO_W'(MIN_DIV));
    state_d     = bnd ? (go_run ? ST_RUN : ST_BYPASS) : state_q;
    act_ratio_d = bnd ? i_div_ratio : act_ratio_q;
    act_en_d    = bnd ? i_clk_en : act_en_q;
    cnt_d       = bnd ? '0 : cnt_q + RATIO_W'(1);
    half        = act_ratio_d - (act_ratio_d >> 1);
    div_d       = (state_d == ST_RUN) && (cnt_d < half);
    tick_d      = (state_d == ST_RUN) && (cnt_d == '0);
  end
  always_comb begin
    o_div_clk = (state_q == ST_RUN) ? div_q : i_ref_clk;
    o_tick    = tick_q;
    o_locked  = (state_q == ST_RUN) && (act_ratio_q == i_div_ratio);
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent integer dividers of i_ref_clk (i_rst sync; bus carries enables, ratios, clocks, ticks, lock)
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int RATIO_W = 8
) (
  input  logic          i_ref_clk,
  input  logic          i_rst,
  clk_div_multi_if.slave bus
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(.RATIO_W(RATIO_W)) u_chan (
      .i_ref_clk   (i_ref_clk),
      .i_rst       (i_rst),
      .i_clk_en    (bus.i_clk_en[c]),
      .i_div_ratio (bus.i_div_ratio[c*RATIO_W +: RATIO_W]),
      .o_div_clk   (bus.o_div_clk[c]),
      .o_tick      (bus.o_tick[c]),
      .o_locked    (bus.o_locked[c])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed plus random stimulus checked against a timestamp-based period model
module tb_clk_div_multi;
  localparam int NCH = 4;
  localparam int RW  = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mrun [NCH];
  int   mr   [NCH];
  int   mt0  [NCH];
  clk_div_multi_if #(.NUM_CH(NCH), .RATIO_W(RW)) bus ();
  clk_div_multi #(.NUM_CH(NCH), .RATIO_W(RW)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  function automatic int ratio_of(input int ch);
    logic [NCH*RW-1:0] v;
    v = bus.i_div_ratio;
    return int'(v[ch*RW +: RW]);
  endfunction
  task automatic set_ch(input int ch, input bit en, input int r);
    logic [NCH*RW-1:0] v;
    v = bus.i_div_ratio;
    v[ch*RW +: RW] = RW'(r);
    bus.i_div_ratio = v;
    bus.i_clk_en[ch] = en;
  endtask
  // A period of ratio R started at cycle mt0 ends at cycle mt0+R-1; bypass re-decides every cycle
  task automatic model_edge();
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst) begin
        mrun[ch] = 1'b0;
        mr[ch]   = 0;
        mt0[ch]  = cyc + 1;
      end else if (!mrun[ch] || (cyc - mt0[ch] == mr[ch] - 1)) begin
        mrun[ch] = bus.i_clk_en[ch] && ratio_of(ch) >= 2;
        mr[ch]   = ratio_of(ch);
        mt0[ch]  = cyc + 1;
      end
    end
    cyc++;
  endtask
  task automatic check_all(input bit ref_lvl);
    int k;
    bit hi;
    for (int ch = 0; ch < NCH; ch++) begin
      k  = cyc - mt0[ch];
      hi = mrun[ch] && (k < (mr[ch] + 1) / 2);
      check_eq($sformatf("div%0d_%0d", ch, ref_lvl), int'(bus.o_div_clk[ch]), mrun[ch] ? int'(hi) : int'(ref_lvl));
      check_eq($sformatf("tick%0d", ch), int'(bus.o_tick[ch]), int'(mrun[ch] && k == 0));
      check_eq($sformatf("lock%0d", ch), int'(bus.o_locked[ch]), int'(mrun[ch] && mr[ch] == ratio_of(ch)));
    end
  endtask
  task automatic run(input int n, input bit rnd);
    int r;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        rst = ($urandom_range(0, 299) == 0);
        for (int ch = 0; ch < NCH; ch++)
          if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 6))
              0: r = 0;
              1: r = 1;
              2: r = 2;
              3: r = 3;
              4: r = 255;
              default: r = $urandom_range(4, 24);
            endcase
            set_ch(ch, $urandom_range(0, 7) != 0, r);
          end
      end
      @(posedge clk);
      model_edge();
      #1;
      check_all(1'b1);
      @(negedge clk);
      check_all(1'b0);
    end
  endtask
  initial begin
    bus.i_clk_en    = '0;
    bus.i_div_ratio = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      mrun[ch] = 1'b0;
      mr[ch]   = 0;
      mt0[ch]  = 0;
    end
    @(negedge clk);
    run(2, 1'b0);
    rst = 1'b0;
    set_ch(0, 1'b1, 4);
    set_ch(1, 1'b1, 5);
    set_ch(2, 1'b1, 6);
    set_ch(3, 1'b0, 7);
    run(7, 1'b0);
    set_ch(1, 1'b1, 2);
    set_ch(2, 1'b1, 1);
    run(20, 1'b0);
    set_ch(0, 1'b1, 255);
    set_ch(1, 1'b1, 0);
    run(600, 1'b0);
    set_ch(0, 1'b1, 8);
    run(4, 1'b0);
    rst = 1'b1;
    run(1, 1'b0);
    rst = 1'b0;
    run(20, 1'b0);
    set_ch(0, 1'b1, 2);
    set_ch(1, 1'b1, 3);
    set_ch(2, 1'b1, 7);
    set_ch(3, 1'b1, 16);
    run(50, 1'b0);
    set_ch(2, 1'b1, 9);
    run(50, 1'b0);
    run(3000, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
